e203_tcm_mport_ctrl: RTL and testbench
======================================

// Module: e203_tcm_mport_ctrl
// PURPOSE
//  N-port ICB-to-single-port-SRAM TCM controller; next generation of the DTCM control path.
//  Replaces the fixed 2-input priority arbiter + SRAM ctrl pair with one parametrised block.
//  Adds selectable round-robin arbitration, out-of-range error responses and a response hold register.
//  Sits between LSU/ext/DMA ICB masters and the TCM SRAM macro; one transaction in flight total.
// PARAMETERS
//  NPORT    2   number of ICB master ports; port 0 is highest priority in fixed mode
//  AW       16  ICB byte-address width
//  DW       32  data width (multiple of 8)
//  RAM_AW   14  SRAM word-address width; in-range iff addr[AW-1:log2(DW/8)] < 2**RAM_AW
//  ARB_RR   0   0 = fixed priority (lowest index wins), 1 = round-robin
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous reset, active-high
//  i_cmd_valid  in   NPORT      per-port command valid
//  i_cmd_ready  out  NPORT      per-port command ready
//  i_cmd_addr   in   NPORT*AW   per-port byte address, naturally aligned
//  i_cmd_read   in   NPORT      1 = read, 0 = write
//  i_cmd_wdata  in   NPORT*DW   per-port write data
//  i_cmd_wmask  in   NPORT*DW/8 per-port byte-enables
//  i_rsp_valid  out  NPORT      per-port response valid (one-hot or zero)
//  i_rsp_ready  in   NPORT      per-port response ready
//  i_rsp_err    out  NPORT      per-port response error
//  i_rsp_rdata  out  NPORT*DW   read data, same value replicated to every port slice
//  ram_cs       out  1          SRAM chip select
//  ram_we       out  1          SRAM write enable
//  ram_addr     out  RAM_AW     SRAM word address
//  ram_wem      out  DW/8       SRAM byte write mask
//  ram_din      out  DW         SRAM write data
//  ram_dout     in   DW         SRAM read data, valid the cycle after ram_cs
//  active       out  1          any cmd_valid or response pending (for upstream clock gating)
// BEHAVIOUR
//  Reset: i_cmd_ready=0 only while rst; rsp_pend=0, i_rsp_valid=0, i_rsp_err=0, hold_vld=0,
//   rr pointer=0, ram_cs=0; rst mid-transaction drops the pending response, no SRAM side effect after.
//  Slot free: free = ~rsp_pend | (i_rsp_valid[owner] & i_rsp_ready[owner]) (back-to-back allowed).
//  Arbitration (comb): grant g among valid ports; fixed = lowest index; RR = first valid at or after
//   rr_ptr, wrapping; on accept rr_ptr <= g+1 mod NPORT. i_cmd_ready[p] = free & (g==p).
//  Accept cycle T (valid&ready): if in range -> ram_cs=1, ram_we=~read, ram_addr=word addr,
//   ram_wem = read ? 0 : wmask, ram_din=wdata; out of range -> ram_cs=0, no SRAM access.
//  Registered at T: rsp_pend=1, owner=g, err=~in_range, hold_vld=0.
//  T+1: i_rsp_valid[owner]=1; rdata = hold_vld ? hold_q : ram_dout (read), 0 for write/error.
//  Stall: if rsp_pend & ~hold_vld & ~i_rsp_ready[owner] -> hold_q<=ram_dout, hold_vld<=1;
//   response stays stable (valid, err, rdata) until handshake.
//  Handshake without new accept -> rsp_pend<=0. Handshake with accept same cycle -> new owner.
//  Minimum latency 1 cycle; throughput 1 txn/cycle with rsp_ready held high.
//  i_rsp_valid never asserted same cycle as its command (no 0-cycle response).
//  ram_cs=0 whenever no accept; ram_addr/din/wem don't-care then but held at 0.
//  Write response: err=0 if in range, rdata=0. Partial wmask writes only enabled bytes.
//  NPORT=1: arbiter degenerates to pass-through; rr_ptr constant 0.
// TESTING
//  Single read: p0 read 0x0010, dout=0xDEADBEEF at T+1, rsp_ready=1 -> rsp_valid[0] at T+1, rdata=0xDEADBEEF.
//  Fixed prio: p0,p1 valid same cycle, ARB_RR=0 -> p0 accepted T, p1 accepted T+1; 2 rsp on 2 cycles.
//  Round-robin: ARB_RR=1, p0,p1 valid for 4 txns -> grant order 0,1,0,1.
//  Stall: read 0x0004, rsp_ready=0 3 cycles, dout changes to 0x1111 -> rdata stays original, no new cs.
//  Out of range: addr = 4*2**RAM_AW -> ram_cs=0, rsp_err=1, rdata=0 at T+1.
//  Reset mid-flight: rst at T+1 with pending rsp -> rsp_valid=0 next cycle, ram_cs=0.

Source files
------------

// File: rtl/e203_tcm_mport_ctrl.sv
// rtl/e203_tcm_mport_ctrl.sv - N-port ICB to single-port SRAM TCM controller
// Arbitrates NPORT ICB masters onto one SRAM, one transaction in flight, with response hold.
module e203_tcm_mport_ctrl #(
    parameter int NPORT  = 2,
    parameter int AW     = 16,
    parameter int DW     = 32,
    parameter int RAM_AW = 14,
    parameter int ARB_RR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NPORT-1:0]      i_cmd_valid,
    output logic [NPORT-1:0]      i_cmd_ready,
    input  logic [NPORT*AW-1:0]   i_cmd_addr,
    input  logic [NPORT-1:0]      i_cmd_read,
    input  logic [NPORT*DW-1:0]   i_cmd_wdata,
    input  logic [NPORT*DW/8-1:0] i_cmd_wmask,
    output logic [NPORT-1:0]      i_rsp_valid,
    input  logic [NPORT-1:0]      i_rsp_ready,
    output logic [NPORT-1:0]      i_rsp_err,
    output logic [NPORT*DW-1:0]   i_rsp_rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic [DW/8-1:0]       ram_wem,
    output logic [DW-1:0]         ram_din,
    input  logic [DW-1:0]         ram_dout,
    output logic                  active
);
    localparam int MW = DW / 8;
    localparam int WS = (MW > 1) ? $clog2(MW) : 0;
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int WW = AW - WS;

    logic          r_rsp_pend;
    logic [PW-1:0] r_owner;
    logic          r_err;
    logic          r_rd;
    logic          r_hold_vld;
    logic [DW-1:0] r_hold_q;
    logic [PW-1:0] r_rr_ptr;

    logic          w_any;
    logic [PW-1:0] w_gnt;
    logic [PW-1:0] w_rr_nxt;
    int            w_k;
    logic          w_free;
    logic          w_accept;
    logic [AW-1:0] w_addr;
    logic [WW-1:0] w_word;
    logic          w_in_range;
    logic          w_read;
    logic [DW-1:0] w_wdata;
    logic [MW-1:0] w_wmask;
    logic [DW-1:0] w_rdata;
    logic          w_unused;

    // Search starts at the RR pointer (or 0 in fixed mode) and wraps.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        w_k   = 0;
        for (int i = 0; i < NPORT; i++) begin
            w_k = (ARB_RR != 0) ? int'(r_rr_ptr) + i : i;
            if (w_k >= NPORT) w_k = w_k - NPORT;
            if (!w_any && i_cmd_valid[w_k]) begin
                w_any = 1'b1;
                w_gnt = PW'(w_k);
            end
        end
        w_rr_nxt = (int'(w_gnt) + 1 >= NPORT) ? '0 : PW'(int'(w_gnt) + 1);
    end

    assign w_free     = ~r_rsp_pend | i_rsp_ready[r_owner];
    assign w_accept   = ~rst & w_free & w_any;
    assign w_addr     = i_cmd_addr[int'(w_gnt)*AW +: AW];
    assign w_word     = w_addr[AW-1:WS];
    assign w_in_range = (w_word >> RAM_AW) == '0;
    assign w_read     = i_cmd_read[w_gnt];
    assign w_wdata    = i_cmd_wdata[int'(w_gnt)*DW +: DW];
    assign w_wmask    = i_cmd_wmask[int'(w_gnt)*MW +: MW];
    assign w_unused   = ^w_addr;

    assign ram_cs   = w_accept & w_in_range;
    assign ram_we   = ram_cs & ~w_read;
    assign ram_addr = ram_cs ? RAM_AW'(w_word) : '0;
    assign ram_wem  = ram_we ? w_wmask : '0;
    assign ram_din  = ram_cs ? w_wdata : '0;

    always_comb begin
        i_cmd_ready = '0;
        i_rsp_valid = '0;
        i_rsp_err   = '0;
        for (int p = 0; p < NPORT; p++) begin
            i_cmd_ready[p] = w_accept & (w_gnt == PW'(p));
            i_rsp_valid[p] = r_rsp_pend & (r_owner == PW'(p));
            i_rsp_err[p]   = r_rsp_pend & (r_owner == PW'(p)) & r_err;
        end
    end

    // Hold register keeps read data stable once the owner stalls.
    assign w_rdata     = (r_rsp_pend & r_rd & ~r_err) ? (r_hold_vld ? r_hold_q : ram_dout) : '0;
    assign i_rsp_rdata = {NPORT{w_rdata}};
    assign active      = (|i_cmd_valid) | r_rsp_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_pend <= 1'b0;
            r_owner    <= '0;
            r_err      <= 1'b0;
            r_rd       <= 1'b0;
            r_hold_vld <= 1'b0;
            r_hold_q   <= '0;
            r_rr_ptr   <= '0;
        end else if (w_accept) begin
            r_rsp_pend <= 1'b1;
            r_owner    <= w_gnt;
            r_err      <= ~w_in_range;
            r_rd       <= w_read;
            r_hold_vld <= 1'b0;
            if (ARB_RR != 0) r_rr_ptr <= w_rr_nxt;
        end else if (r_rsp_pend & i_rsp_ready[r_owner]) begin
            r_rsp_pend <= 1'b0;
            r_hold_vld <= 1'b0;
        end else if (r_rsp_pend & ~r_hold_vld) begin
            r_hold_q   <= ram_dout;
            r_hold_vld <= 1'b1;
        end
    end
endmodule

// File: tb/tb_e203_tcm_mport_ctrl.sv
// tb/tb_e203_tcm_mport_ctrl.sv - directed bench for fixed and round-robin controller instances
module tb_e203_tcm_mport_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cmd_valid;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_read;
    logic [63:0] cmd_wdata;
    logic [7:0]  cmd_wmask;
    logic [1:0]  rsp_ready;
    logic [31:0] ram_dout;

    logic [1:0]  fx_cmd_ready, fx_rsp_valid, fx_rsp_err;
    logic [63:0] fx_rsp_rdata;
    logic        fx_ram_cs, fx_ram_we, fx_active;
    logic [7:0]  fx_ram_addr;
    logic [3:0]  fx_ram_wem;
    logic [31:0] fx_ram_din;

    logic [1:0]  rr_cmd_ready, rr_rsp_valid, rr_rsp_err;
    logic [63:0] rr_rsp_rdata;
    logic        rr_ram_cs, rr_ram_we, rr_active;
    logic [7:0]  rr_ram_addr;
    logic [3:0]  rr_ram_wem;
    logic [31:0] rr_ram_din;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    e203_tcm_mport_ctrl #(.NPORT(2), .AW(16), .DW(32), .RAM_AW(8), .ARB_RR(0)) u_fx (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid), .i_cmd_ready(fx_cmd_ready), .i_cmd_addr(cmd_addr),
        .i_cmd_read(cmd_read), .i_cmd_wdata(cmd_wdata), .i_cmd_wmask(cmd_wmask),
        .i_rsp_valid(fx_rsp_valid), .i_rsp_ready(rsp_ready), .i_rsp_err(fx_rsp_err),
        .i_rsp_rdata(fx_rsp_rdata),
        .ram_cs(fx_ram_cs), .ram_we(fx_ram_we), .ram_addr(fx_ram_addr), .ram_wem(fx_ram_wem),
        .ram_din(fx_ram_din), .ram_dout(ram_dout), .active(fx_active)
    );

    e203_tcm_mport_ctrl #(.NPORT(2), .AW(16), .DW(32), .RAM_AW(8), .ARB_RR(1)) u_rr (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid), .i_cmd_ready(rr_cmd_ready), .i_cmd_addr(cmd_addr),
        .i_cmd_read(cmd_read), .i_cmd_wdata(cmd_wdata), .i_cmd_wmask(cmd_wmask),
        .i_rsp_valid(rr_rsp_valid), .i_rsp_ready(rsp_ready), .i_rsp_err(rr_rsp_err),
        .i_rsp_rdata(rr_rsp_rdata),
        .ram_cs(rr_ram_cs), .ram_we(rr_ram_we), .ram_addr(rr_ram_addr), .ram_wem(rr_ram_wem),
        .ram_din(rr_ram_din), .ram_dout(ram_dout), .active(rr_active)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input int p, input logic [15:0] a, input logic rd,
                           input logic [31:0] wd, input logic [3:0] wm);
        cmd_addr[p*16 +: 16] = a;
        cmd_read[p]          = rd;
        cmd_wdata[p*32 +: 32] = wd;
        cmd_wmask[p*4 +: 4]  = wm;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = '0; cmd_addr = '0; cmd_read = '0;
        cmd_wdata = '0; cmd_wmask = '0; rsp_ready = 2'b11; ram_dout = '0;
        tick(); tick();
        cmd_valid = 2'b11;
        #1;
        chk("rst_ready_fx", fx_cmd_ready, 2'b00);
        chk("rst_ready_rr", rr_cmd_ready, 2'b00);
        chk("rst_cs", fx_ram_cs, 1'b0);
        chk("rst_rspv", fx_rsp_valid, 2'b00);

        tick(); rst = 1'b0; cmd_valid = 2'b00;
        #1;
        chk("idle_ready", fx_cmd_ready, 2'b00);
        chk("idle_active", fx_active, 1'b0);

        // single read
        tick(); cmd_valid = 2'b01; set_cmd(0, 16'h0010, 1'b1, 32'h0, 4'h0);
        #1;
        chk("rd_ready", fx_cmd_ready, 2'b01);
        chk("rd_cs", fx_ram_cs, 1'b1);
        chk("rd_we", fx_ram_we, 1'b0);
        chk("rd_addr", fx_ram_addr, 8'h04);
        chk("rd_wem", fx_ram_wem, 4'h0);
        tick(); cmd_valid = 2'b00; ram_dout = 32'hDEADBEEF;
        #1;
        chk("rd_rspv", fx_rsp_valid, 2'b01);
        chk("rd_rdata", fx_rsp_rdata, {2{32'hDEADBEEF}});
        chk("rd_err", fx_rsp_err, 2'b00);
        chk("rd_cs_t1", fx_ram_cs, 1'b0);
        chk("rd_active", fx_active, 1'b1);
        tick();
        #1;
        chk("rd_done", fx_rsp_valid, 2'b00);

        // partial write from port 1
        cmd_valid = 2'b10; set_cmd(1, 16'h0020, 1'b0, 32'hA5A51234, 4'b0101);
        #1;
        chk("wr_ready", fx_cmd_ready, 2'b10);
        chk("wr_we", fx_ram_we, 1'b1);
        chk("wr_addr", fx_ram_addr, 8'h08);
        chk("wr_wem", fx_ram_wem, 4'b0101);
        chk("wr_din", fx_ram_din, 32'hA5A51234);
        tick(); cmd_valid = 2'b00; ram_dout = 32'hFFFFFFFF;
        #1;
        chk("wr_rspv", fx_rsp_valid, 2'b10);
        chk("wr_rdata", fx_rsp_rdata, 64'h0);
        chk("wr_err", fx_rsp_err, 2'b00);

        // both ports valid: fixed keeps p0, round-robin alternates
        tick(); cmd_valid = 2'b11;
        set_cmd(0, 16'h0040, 1'b1, 32'h0, 4'h0);
        set_cmd(1, 16'h0080, 1'b1, 32'h0, 4'h0);
        #1;
        chk("arb1_fx", fx_cmd_ready, 2'b01);
        chk("arb1_rr", rr_cmd_ready, 2'b01);
        tick(); #1;
        chk("arb2_fx", fx_cmd_ready, 2'b01);
        chk("arb2_rr", rr_cmd_ready, 2'b10);
        chk("arb2_rr_addr", rr_ram_addr, 8'h20);
        chk("arb2_fx_addr", fx_ram_addr, 8'h10);
        chk("arb2_rspv_rr", rr_rsp_valid, 2'b01);
        tick(); #1;
        chk("arb3_fx", fx_cmd_ready, 2'b01);
        chk("arb3_rr", rr_cmd_ready, 2'b01);
        chk("arb3_rspv_rr", rr_rsp_valid, 2'b10);
        tick(); #1;
        chk("arb4_rr", rr_cmd_ready, 2'b10);
        chk("arb4_rspv_fx", fx_rsp_valid, 2'b01);
        tick(); cmd_valid = 2'b10;
        #1;
        chk("arb5_fx", fx_cmd_ready, 2'b10);
        chk("arb5_rr", rr_cmd_ready, 2'b10);
        chk("arb5_rspv_fx", fx_rsp_valid, 2'b01);
        chk("arb5_rspv_rr", rr_rsp_valid, 2'b10);
        tick(); cmd_valid = 2'b00;
        #1;
        chk("arb6_rspv_fx", fx_rsp_valid, 2'b10);
        tick(); #1;
        chk("arb7_rspv_fx", fx_rsp_valid, 2'b00);

        // stall with hold register, then back-to-back accept on release
        cmd_valid = 2'b01; set_cmd(0, 16'h0004, 1'b1, 32'h0, 4'h0);
        #1;
        chk("st_cs", fx_ram_cs, 1'b1);
        chk("st_addr", fx_ram_addr, 8'h01);
        tick(); cmd_valid = 2'b00; rsp_ready = 2'b00; ram_dout = 32'hCAFEF00D;
        #1;
        chk("st0_rdata", fx_rsp_rdata, {2{32'hCAFEF00D}});
        tick(); ram_dout = 32'h00001111; cmd_valid = 2'b10;
        set_cmd(1, 16'h0008, 1'b1, 32'h0, 4'h0);
        #1;
        chk("st1_rdata", fx_rsp_rdata, {2{32'hCAFEF00D}});
        chk("st1_rspv", fx_rsp_valid, 2'b01);
        chk("st1_ready", fx_cmd_ready, 2'b00);
        chk("st1_cs", fx_ram_cs, 1'b0);
        tick(); #1;
        chk("st2_rdata", fx_rsp_rdata, {2{32'hCAFEF00D}});
        chk("st2_cs", fx_ram_cs, 1'b0);
        tick(); rsp_ready = 2'b11;
        #1;
        chk("st3_rdata", fx_rsp_rdata, {2{32'hCAFEF00D}});
        chk("st3_ready", fx_cmd_ready, 2'b10);
        chk("st3_addr", fx_ram_addr, 8'h02);
        tick(); cmd_valid = 2'b00; ram_dout = 32'h22223333;
        #1;
        chk("st4_rspv", fx_rsp_valid, 2'b10);
        chk("st4_rdata", fx_rsp_rdata, {2{32'h22223333}});
        tick(); #1;
        chk("st5_rspv", fx_rsp_valid, 2'b00);

        // last in-range word, then first out-of-range word
        cmd_valid = 2'b01; set_cmd(0, 16'h03FC, 1'b1, 32'h0, 4'h0);
        #1;
        chk("edge_cs", fx_ram_cs, 1'b1);
        chk("edge_addr", fx_ram_addr, 8'hFF);
        tick(); set_cmd(0, 16'h0400, 1'b1, 32'h0, 4'h0); ram_dout = 32'h12345678;
        #1;
        chk("edge_err", fx_rsp_err, 2'b00);
        chk("oor_ready", fx_cmd_ready, 2'b01);
        chk("oor_cs", fx_ram_cs, 1'b0);
        tick(); cmd_valid = 2'b00; ram_dout = 32'hFFFFFFFF;
        #1;
        chk("oor_rspv", fx_rsp_valid, 2'b01);
        chk("oor_err", fx_rsp_err, 2'b01);
        chk("oor_rdata", fx_rsp_rdata, 64'h0);

        // reset while a response is pending
        tick(); cmd_valid = 2'b01; set_cmd(0, 16'h0010, 1'b1, 32'h0, 4'h0);
        #1;
        chk("rm_cs", fx_ram_cs, 1'b1);
        tick(); rst = 1'b1;
        #1;
        chk("rm_rst_cs", fx_ram_cs, 1'b0);
        chk("rm_rst_ready", fx_cmd_ready, 2'b00);
        tick(); rst = 1'b0; cmd_valid = 2'b00;
        #1;
        chk("rm_rspv", fx_rsp_valid, 2'b00);
        chk("rm_cs_after", fx_ram_cs, 1'b0);
        chk("rm_active", fx_active, 1'b0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
